// File: rtl/fpu_pkg.sv
// Shared FP32 field positions, constants and the sequential-unit state encoding.
package fpu_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_W   = 23;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
  localparam logic [31:0] FP_INF_POS = 32'h7F80_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_NORM,
    ST_DONE
  } state_t;

endpackage

// File: rtl/fp_normalize_pack.sv
// Normalises the top of a 48-bit mantissa product and packs an FP32 word.
// Truncating rounding; zero/underflow flush to +0, overflow saturates to signed Inf.
module fp_normalize_pack
  import fpu_pkg::*;
(
  input  logic [FRAC_W+1:0]  acc_hi,
  input  logic signed [9:0]  exponent,
  input  logic               sign,
  input  logic               zero,
  output logic [31:0]        result,
  output logic               overflow
);

  logic signed [9:0]   exp_adj;
  logic [FRAC_W-1:0]   man;

  always_comb begin
    result   = FP_ZERO;
    overflow = 1'b0;
    // acc_hi is product bits [47:23]; bit 47 set means the product is in [2,4)
    if (acc_hi[FRAC_W+1]) begin
      exp_adj = exponent + 10'sd1;
      man     = acc_hi[FRAC_W:1];
    end else begin
      exp_adj = exponent;
      man     = acc_hi[FRAC_W-1:0];
    end

    if (zero) begin
      result = FP_ZERO;
    end else if (exp_adj >= 10'(EXP_MAX)) begin
      result   = FP_INF_POS | {sign, 31'h0};
      overflow = 1'b1;
    end else if (exp_adj <= 10'sd0) begin
      result = FP_ZERO;
    end else begin
      result = {sign, exp_adj[7:0], man};
    end
  end

endmodule

// File: rtl/fp_seq_multiplier.sv
// Multi-cycle FP32 multiplier: one radix-2 shift-add partial product per cycle,
// fixed 26-cycle accept-to-result latency, valid/ready on both sides.
module fp_seq_multiplier
  import fpu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int MAN_W = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            overflow
);

  localparam int CNT_W = $clog2(MAN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAN_W - 1);

  state_t                 state_reg, state_next;
  logic [2*MAN_W-1:0]     acc_reg;
  logic [MAN_W-1:0]       ma_reg, mb_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic signed [9:0]      exp_reg;
  logic                   sign_reg, zero_reg;
  logic [XLEN-1:0]        result_reg;
  logic                   overflow_reg;

  logic [XLEN-1:0]        pack_result;
  logic                   pack_overflow;

  fp_normalize_pack u_pack (
    .acc_hi   (acc_reg[2*MAN_W-1:MAN_W-1]),
    .exponent (exp_reg),
    .sign     (sign_reg),
    .zero     (zero_reg),
    .result   (pack_result),
    .overflow (pack_overflow)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (in_valid)             state_next = ST_MUL;
      ST_MUL:  if (cnt_reg == CNT_LAST)  state_next = ST_NORM;
      ST_NORM:                           state_next = ST_DONE;
      ST_DONE: if (out_ready)            state_next = ST_IDLE;
      default:                           state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      acc_reg      <= '0;
      ma_reg       <= '0;
      mb_reg       <= '0;
      cnt_reg      <= '0;
      exp_reg      <= '0;
      sign_reg     <= 1'b0;
      zero_reg     <= 1'b0;
      result_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            sign_reg <= A[SIGN_BIT] ^ B[SIGN_BIT];
            zero_reg <= (A[EXP_MSB:EXP_LSB] == '0) || (B[EXP_MSB:EXP_LSB] == '0);
            exp_reg  <= {2'b00, A[EXP_MSB:EXP_LSB]} + {2'b00, B[EXP_MSB:EXP_LSB]}
                        - 10'(EXP_BIAS);
            ma_reg   <= {1'b1, A[FRAC_W-1:0]};
            mb_reg   <= {1'b1, B[FRAC_W-1:0]};
            acc_reg  <= '0;
            cnt_reg  <= '0;
          end
        end
        ST_MUL: begin
          // Zero operands still run all iterations so latency never varies
          if (mb_reg[cnt_reg])
            acc_reg <= acc_reg + ({{MAN_W{1'b0}}, ma_reg} << cnt_reg);
          cnt_reg <= cnt_reg + 1'b1;
        end
        ST_NORM: begin
          result_reg   <= pack_result;
          overflow_reg <= pack_overflow;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign result    = result_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_fp_seq_multiplier.sv
// Self-checking bench for fp_seq_multiplier: scoreboard queue filled at accept,
// drained and compared when out_valid is observed.
module tb_fp_seq_multiplier;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [32:0] exp_q[$];

  fp_seq_multiplier dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a_in),
    .B         (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: full-width integer product, independent of the shift-add order.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [22:0] man;
    logic        s;
    int          e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'h0 || b[30:23] == 8'h0) return 33'h0;
    p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      e++;
      man = p[46:24];
    end else begin
      man = p[45:23];
    end
    if (e >= 255) return {1'b1, s, 8'hFF, 23'h0};
    if (e <= 0)   return 33'h0;
    return {1'b0, s, e[7:0], man};
  endfunction

  // Waits for in_ready, presents operands for one accept edge; optionally scores it.
  task automatic do_accept(input logic [31:0] a, input logic [31:0] b, input bit push,
                           output bit ok);
    int w;
    ok = 1'b1;
    w  = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
      ok = 1'b0;
    end else begin
      a_in = a;
      b_in = b;
      in_valid = 1'b1;
      @(posedge clk);
      if (push) exp_q.push_back(model(a, b));
      #1;
      in_valid = 1'b0;
    end
  endtask

  // Counts negedges after the accept edge until out_valid is seen (26 expected).
  task automatic wait_out(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 00000000", result); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    rst_n = 1'b1;
    $display("reset: in_ready=%b out_valid=%b result=%h overflow=%b", in_ready, out_valid, result, overflow);
  endtask

  task automatic test_directed();
    logic [31:0] va[7] = '{32'h40000000, 32'h3FC00000, 32'hC0000000, 32'h00000000,
                           32'h80000000, 32'h7F000000, 32'h00800000};
    logic [31:0] vb[7] = '{32'h40400000, 32'h3FC00000, 32'h3F000000, 32'h40400000,
                           32'hC0000000, 32'h7F000000, 32'h00800000};
    logic [32:0] vx[7] = '{{1'b0, 32'h40C00000}, {1'b0, 32'h40100000}, {1'b0, 32'hBF800000},
                           {1'b0, 32'h00000000}, {1'b0, 32'h00000000}, {1'b1, 32'h7F800000},
                           {1'b0, 32'h00000000}};
    for (int i = 0; i < 7; i++) begin
      bit          ok;
      int          lat;
      logic [32:0] want;
      do_accept(va[i], vb[i], 1'b1, ok);
      if (!ok) continue;
      wait_out(lat, ok);
      want = exp_q.pop_front();
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL directed_%0d_timeout: out_valid never rose", i);
        continue;
      end
      if (lat !== 26) begin n_fail++; $display("FAIL directed_%0d_latency: got %0d want 26", i, lat); end
      n_checks++;
      if (want !== vx[i]) begin n_fail++; $display("FAIL directed_%0d_model: model %h want %h", i, want, vx[i]); end
      n_checks++;
      if ({overflow, result} !== want) begin
        n_fail++;
        $display("FAIL directed_%0d_result: got ovf=%b res=%h want ovf=%b res=%h",
                 i, overflow, result, want[32], want[31:0]);
      end
      $display("directed %0d: A=%h B=%h -> res=%h ovf=%b lat=%0d", i, va[i], vb[i], result, overflow, lat);
      handshake();
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL directed_%0d_release: out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    bit          ok;
    int          lat;
    logic [32:0] want;
    do_accept(32'h40000000, 32'h40400000, 1'b1, ok);
    if (!ok) return;
    // Operands offered while busy must be ignored
    a_in = 32'h7F7FFFFF;
    b_in = 32'h7F7FFFFF;
    in_valid = 1'b1;
    wait_out(lat, ok);
    want = exp_q.pop_front();
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL backpressure_timeout: out_valid never rose");
      in_valid = 1'b0;
      return;
    end
    if (lat !== 26) begin n_fail++; $display("FAIL backpressure_latency: got %0d want 26", lat); end
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {overflow, result} !== want) begin
        n_fail++;
        $display("FAIL backpressure_hold_%0d: ov=%b ir=%b res=%h ovf=%b want 1/0/%h/%b",
                 c, out_valid, in_ready, result, overflow, want[31:0], want[32]);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    $display("backpressure: res=%h held 5 cycles", result);
    handshake();
  endtask

  task automatic test_abort();
    bit ok;
    bit seen;
    do_accept(32'h40000000, 32'h40400000, 1'b0, ok);
    if (!ok) return;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_stale_output: out_valid seen=%b want 0", seen); end
    $display("abort: in_ready=%b stale_out_valid=%b", in_ready, seen);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bit          ok;
      int          lat;
      logic [32:0] want;
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if (i % 2 == 0) begin
        a[30:23] = 8'($urandom_range(100, 154));
        b[30:23] = 8'($urandom_range(100, 154));
      end
      do_accept(a, b, 1'b1, ok);
      if (!ok) break;
      wait_out(lat, ok);
      want = exp_q.pop_front();
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL b2b_%0d_timeout: out_valid never rose", i);
        continue;
      end
      if (lat !== 26 || {overflow, result} !== want) begin
        n_fail++;
        $display("FAIL b2b_%0d: lat=%0d res=%h ovf=%b want lat=26 res=%h ovf=%b",
                 i, lat, result, overflow, want[31:0], want[32]);
      end
      $display("b2b %0d: A=%h B=%h -> res=%h ovf=%b", i, a, b, result, overflow);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = 32'h0;
    b_in      = 32'h0;
    test_reset();
    test_directed();
    test_backpressure();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
